sysop_arbiter: RTL and testbench
================================

Name: sysop_arbiter

Overview:
- Shares one SYSTEM execution unit (counter bank plus SCALL/SBREAK decode) between NUM_REQ hardware threads/cores in the multicore design.
- Arbitrates round-robin, sequences each accepted op through the unit, and returns the registered 32-bit result to the winning requester with a valid/ready handshake.
- Converts SCALL/SBREAK into a one-cycle trap pulse tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), requester id width (derived, not overridden).

Ports:
- i_aclk  in  1  clock
- i_areset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester op request
- i_req_op  in  NUM_REQ x t_sysop  per-requester op; held stable while valid
- o_req_ready  out  NUM_REQ  one-hot accept strobe
- o_rsp_valid  out  NUM_REQ  one-hot response valid
- i_rsp_ready  in  NUM_REQ  per-requester response accept
- o_rsp_data  out  DATA_SIZE  shared response data
- o_rsp_err  out  1  response error flag (unsupported op)
- o_exe_op  out  t_sysop  op driven to the shared execution unit
- i_exe_result  in  DATA_SIZE  combinational result from the execution unit
- o_trap_valid  out  1  one-cycle trap pulse
- o_trap_id  out  ID_W  requester that trapped
- o_trap_break  out  1  1 = SBREAK, 0 = SCALL
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-low on i_areset_n): state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0, o_exe_op=RDCYCLE.
- Reset mid-operation aborts the op: no response, no trap.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any i_req_valid, pick the first set bit searching from rr_ptr+1 modulo NUM_REQ.
  - Assert o_req_ready for that requester in the same cycle (combinational on valid).
  - Latch op and id, set rr_ptr=id, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC, exactly 1 cycle:
  - o_exe_op = latched op.
  - RDCYCLE/RDCYCLEH/RDTIME/RDTIMEH/RDINSTRET/RDINSTRETH: register i_exe_result into o_rsp_data, o_rsp_err=0.
  - SCALL/SBREAK: o_rsp_data=0, o_rsp_err=0. Pulse o_trap_valid for the one cycle after EXEC (aligned with RESP entry), with o_trap_id=id and o_trap_break set accordingly.
  - Any other encoding: o_rsp_data=0, o_rsp_err=1, no trap.
  - Go to RESP.
- RESP:
  - o_rsp_valid[id]=1. o_rsp_data and o_rsp_err are held until i_rsp_ready[id]=1.
  - On handshake go to IDLE.
  - i_rsp_ready of non-selected requesters is ignored.
- Timing:
  - Latency from accept to rsp_valid is 2 cycles.
  - Minimum spacing between accepts is 3 cycles.
  - o_exe_op = RDCYCLE outside EXEC.
- Fairness: a continuously requesting thread waits at most NUM_REQ-1 grants.
- Requesters are not accepted during EXEC/RESP. o_req_ready=0 outside IDLE.
- A requester dropping valid before accept is legal. It is simply not selected.
- If exactly one requester is valid, it wins regardless of rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Outputs o_rsp_valid and o_req_ready are never multi-hot.
- No combinational path from i_exe_result to any output. o_req_ready is combinational from i_req_valid only in IDLE.

Test Plan:
- Reset, then req_valid=4'b0001, op=RDCYCLE, rsp_ready=1 -> ready[0] cycle 0; rsp_valid[0] cycle 2; data equals the unit's cycle count sampled in EXEC; back to IDLE cycle 3.
- All four valid continuously with RDINSTRET, rsp_ready=1 -> grant order 0,1,2,3,0,1; accepts exactly 3 cycles apart; no multi-hot ready.
- Requester 2 issues SBREAK, then requester 1 issues SCALL -> trap_valid one cycle each, trap_id=2 with break=1, then trap_id=1 with break=0; rsp_data=0, rsp_err=0 both times.
- Requester 3 issues an illegal op encoding -> rsp_valid[3], rsp_err=1, data 0, no trap.
- Response backpressure: rsp_ready[0]=0 for 5 cycles while req_valid[1]=1 -> rsp_valid[0] and data held stable; ready[1] asserted only on the cycle after the handshake; o_busy=1 throughout.
- Assert i_areset_n low during EXEC -> all outputs 0 immediately; no rsp_valid or trap afterward; the next grant goes to requester 0.

Source files
------------

// File: rtl/sysop_arbiter_if.sv
// Shared SYSTEM-op types and the requester-side handshake bundle of sysop_arbiter.
// Opcodes 8..15 are left undefined and are answered with an error response.
package sysop_pkg;
   localparam int unsigned DATA_SIZE = 32;

   typedef enum logic [3:0] {
      RDCYCLE    = 4'h0,
      RDCYCLEH   = 4'h1,
      RDTIME     = 4'h2,
      RDTIMEH    = 4'h3,
      RDINSTRET  = 4'h4,
      RDINSTRETH = 4'h5,
      SCALL      = 4'h6,
      SBREAK     = 4'h7
   } t_sysop;
endpackage

interface sysop_arbiter_if
   import sysop_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]   i_req_valid;
   t_sysop               i_req_op [NUM_REQ];
   logic [NUM_REQ-1:0]   o_req_ready;
   logic [NUM_REQ-1:0]   o_rsp_valid;
   logic [NUM_REQ-1:0]   i_rsp_ready;
   logic [DATA_SIZE-1:0] o_rsp_data;
   logic                 o_rsp_err;

   modport slave (
      input  i_req_valid, i_req_op, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
   );

   modport master (
      output i_req_valid, i_req_op, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
   );
endinterface

// File: rtl/sysop_arbiter.sv
// Round-robin arbiter sharing one SYSTEM execution unit between NUM_REQ requesters;
// one op in flight, registered result returned per requester, SCALL/SBREAK raise a trap pulse.
module sysop_arbiter
   import sysop_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 i_aclk,
   input  logic                 i_areset_n,
   sysop_arbiter_if.slave       bus,
   output t_sysop               o_exe_op,
   input  logic [DATA_SIZE-1:0] i_exe_result,
   output logic                 o_trap_valid,
   output logic [ID_W-1:0]      o_trap_id,
   output logic                 o_trap_break,
   output logic                 o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } t_state;

   t_state               state_q;
   logic [ID_W-1:0]      rr_q;
   logic [ID_W-1:0]      id_q;
   t_sysop               exe_op_q;
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic [DATA_SIZE-1:0] rsp_data_q;
   logic                 rsp_err_q;
   logic                 trap_valid_q;
   logic [ID_W-1:0]      trap_id_q;
   logic                 trap_break_q;
   logic                 busy_q;

   logic                 grant_found;
   logic [ID_W-1:0]      grant_id;
   logic [ID_W-1:0]      scan_id;
   logic [NUM_REQ-1:0]   req_ready;

   // Scan starts just after the last winner, so a lone requester always wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_id     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_id = ID_W'((32'(rr_q) + k) % NUM_REQ);
         if (!grant_found && bus.i_req_valid[scan_id]) begin
            grant_found = 1'b1;
            grant_id    = scan_id;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (i_areset_n && (state_q == ST_IDLE) && grant_found) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state_q      <= ST_IDLE;
         rr_q         <= ID_W'(NUM_REQ - 1);
         id_q         <= '0;
         exe_op_q     <= RDCYCLE;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         trap_valid_q <= 1'b0;
         trap_id_q    <= '0;
         trap_break_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         trap_valid_q <= 1'b0;
         trap_id_q    <= '0;
         trap_break_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_found) begin
                  id_q     <= grant_id;
                  rr_q     <= grant_id;
                  exe_op_q <= bus.i_req_op[grant_id];
                  busy_q   <= 1'b1;
                  state_q  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // exe_op_q doubles as the latched op; it reverts to RDCYCLE once EXEC ends.
               exe_op_q          <= RDCYCLE;
               rsp_valid_q[id_q] <= 1'b1;
               state_q           <= ST_RESP;
               case (exe_op_q)
                  RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH, RDINSTRET, RDINSTRETH: begin
                     rsp_data_q <= i_exe_result;
                     rsp_err_q  <= 1'b0;
                  end
                  SCALL, SBREAK: begin
                     rsp_data_q   <= '0;
                     rsp_err_q    <= 1'b0;
                     trap_valid_q <= 1'b1;
                     trap_id_q    <= id_q;
                     trap_break_q <= (exe_op_q == SBREAK);
                  end
                  default: begin
                     rsp_data_q <= '0;
                     rsp_err_q  <= 1'b1;
                  end
               endcase
            end
            ST_RESP: begin
               if (bus.i_rsp_ready[id_q]) begin
                  rsp_valid_q <= '0;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_req_ready = req_ready;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_data  = rsp_data_q;
   assign bus.o_rsp_err   = rsp_err_q;
   assign o_exe_op        = exe_op_q;
   assign o_trap_valid    = trap_valid_q;
   assign o_trap_id       = trap_id_q;
   assign o_trap_break    = trap_break_q;
   assign o_busy          = busy_q;

endmodule

// File: tb/tb_sysop_arbiter.sv
// Bench for sysop_arbiter: a per-transaction model checked every cycle, plus directed
// scenarios with hand-computed expectations (grant order, traps, backpressure, reset abort).
module tb_sysop_arbiter;
   import sysop_pkg::*;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   t_sysop      exe_op;
   logic [31:0] exe_result;
   logic        trap_valid;
   logic [1:0]  trap_id;
   logic        trap_break;
   logic        busy;

   int checks = 0;
   int errors = 0;

   sysop_arbiter_if #(.NUM_REQ(NR)) bus ();

   sysop_arbiter #(.NUM_REQ(NR)) dut (
      .i_aclk       (clk),
      .i_areset_n   (rst_n),
      .bus          (bus),
      .o_exe_op     (exe_op),
      .i_exe_result (exe_result),
      .o_trap_valid (trap_valid),
      .o_trap_id    (trap_id),
      .o_trap_break (trap_break),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in execution unit: opcode in the top nibble, cycle count below.
   assign exe_result = {exe_op, 28'(cyc)};

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_cur  = -1;      // requester being served, -1 when none
   int          m_last = NR - 1;  // last winner
   int          m_age  = 0;       // cycles since accept
   logic [3:0]  m_op   = '0;
   logic [31:0] m_data = '0;
   logic        m_err  = 1'b0;

   always @(negedge clk) begin
      int         pick;
      logic [3:0] e_ready, e_rspv;
      logic [3:0] e_exe;
      logic       e_trap;
      if (!rst_n) begin
         m_cur  = -1;
         m_last = NR - 1;
         m_age  = 0;
         chk("m_rst_ready", 64'(bus.o_req_ready), 64'(0));
         chk("m_rst_rspv", 64'(bus.o_rsp_valid), 64'(0));
         chk("m_rst_exe", 64'(exe_op), 64'(0));
         chk("m_rst_trap", 64'(trap_valid), 64'(0));
         chk("m_rst_busy", 64'(busy), 64'(0));
      end else begin
         pick = -1;
         for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_last + k) % NR;
            if (pick < 0 && bus.i_req_valid[j]) pick = j;
         end
         e_ready = (m_cur < 0 && pick >= 0) ? 4'(1 << pick) : 4'b0;
         e_exe   = (m_cur >= 0 && m_age == 1) ? m_op : 4'h0;
         e_rspv  = (m_cur >= 0 && m_age >= 2) ? 4'(1 << m_cur) : 4'b0;
         e_trap  = (m_cur >= 0 && m_age == 2 && (m_op == 4'h6 || m_op == 4'h7));
         chk("m_ready", 64'(bus.o_req_ready), 64'(e_ready));
         chk("m_exe_op", 64'(exe_op), 64'(e_exe));
         chk("m_rsp_valid", 64'(bus.o_rsp_valid), 64'(e_rspv));
         chk("m_busy", 64'(busy), 64'(m_cur >= 0));
         chk("m_trap_valid", 64'(trap_valid), 64'(e_trap));
         if (e_trap) begin
            chk("m_trap_id", 64'(trap_id), 64'(m_cur));
            chk("m_trap_break", 64'(trap_break), 64'(m_op == 4'h7));
         end
         if (e_rspv != 0) begin
            chk("m_rsp_data", 64'(bus.o_rsp_data), 64'(m_data));
            chk("m_rsp_err", 64'(bus.o_rsp_err), 64'(m_err));
         end
         // advance to what the next clock edge must produce
         if (m_cur < 0) begin
            if (pick >= 0) begin
               m_cur  = pick;
               m_last = pick;
               m_age  = 1;
               m_op   = 4'(bus.i_req_op[pick]);
            end
         end else if (m_age == 1) begin
            m_age  = 2;
            m_data = (m_op <= 4'h5) ? {m_op, 28'(cyc)} : 32'h0;
            m_err  = (m_op > 4'h7);
         end else if (bus.i_rsp_ready[m_cur]) begin
            m_cur = -1;
         end else begin
            m_age = 3;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_inputs();
      bus.i_req_valid = '0;
      bus.i_rsp_ready = '1;
      for (int i = 0; i < NR; i++) bus.i_req_op[i] = RDCYCLE;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_ready(input int id, output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_req_ready[id] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_seen", 64'(bus.o_req_ready[id]), 64'(1));
      c = cyc;
   endtask

   // One op from one requester with rsp_ready all high; samples the RESP cycle and the one after.
   task automatic txn(input int id, input logic [3:0] op,
                      output logic [3:0] rv, output logic [31:0] d, output logic e,
                      output logic tv, output logic [1:0] tid, output logic tb,
                      output logic tv_after, output logic busy_after, output int c0);
      @(posedge clk); #1;
      bus.i_rsp_ready     = '1;
      bus.i_req_op[id]    = t_sysop'(op);
      bus.i_req_valid[id] = 1'b1;
      wait_ready(id, c0);
      @(posedge clk); #1;
      bus.i_req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rv  = bus.o_rsp_valid;
      d   = bus.o_rsp_data;
      e   = bus.o_rsp_err;
      tv  = trap_valid;
      tid = trap_id;
      tb  = trap_break;
      @(negedge clk);
      tv_after   = trap_valid;
      busy_after = busy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  rv;
      logic [31:0] d;
      logic        e, tv, tb, tva, ba;
      logic [1:0]  tid;
      int          c0;
      int          gid[$];
      int          gcyc[$];
      int          exp_order[6] = '{0, 1, 2, 3, 0, 1};

      clear_inputs();
      do_reset();

      // T1: single RDCYCLE from requester 0
      txn(0, 4'h0, rv, d, e, tv, tid, tb, tva, ba, c0);
      chk("t1_rsp_valid", 64'(rv), 64'(4'b0001));
      chk("t1_data", 64'(d), 64'({4'h0, 28'(c0 + 1)}));
      chk("t1_err", 64'(e), 64'(0));
      chk("t1_idle_after", 64'(ba), 64'(0));

      // T2: all four requesting RDINSTRET from reset
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) bus.i_req_op[i] = RDINSTRET;
      bus.i_req_valid = '1;
      repeat (17) begin
         @(negedge clk);
         chk("t2_onehot", 64'($onehot0(bus.o_req_ready)), 64'(1));
         for (int i = 0; i < NR; i++)
            if (bus.o_req_ready[i]) begin
               gid.push_back(i);
               gcyc.push_back(cyc);
            end
      end
      @(posedge clk); #1;
      bus.i_req_valid = '0;
      repeat (3) @(posedge clk);
      chk("t2_grants", 64'(gid.size()), 64'(6));
      for (int i = 0; i < 6 && i < gid.size(); i++) begin
         chk("t2_order", 64'(gid[i]), 64'(exp_order[i]));
         if (i > 0) chk("t2_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(3));
      end

      // T3: SBREAK from 2 then SCALL from 1
      txn(2, 4'h7, rv, d, e, tv, tid, tb, tva, ba, c0);
      chk("t3a_rsp_valid", 64'(rv), 64'(4'b0100));
      chk("t3a_data", 64'(d), 64'(0));
      chk("t3a_err", 64'(e), 64'(0));
      chk("t3a_trap", 64'({tv, tid, tb}), 64'({1'b1, 2'd2, 1'b1}));
      chk("t3a_trap_pulse", 64'(tva), 64'(0));
      txn(1, 4'h6, rv, d, e, tv, tid, tb, tva, ba, c0);
      chk("t3b_rsp_valid", 64'(rv), 64'(4'b0010));
      chk("t3b_data", 64'(d), 64'(0));
      chk("t3b_err", 64'(e), 64'(0));
      chk("t3b_trap", 64'({tv, tid, tb}), 64'({1'b1, 2'd1, 1'b0}));
      chk("t3b_trap_pulse", 64'(tva), 64'(0));

      // T4: illegal encoding from 3
      txn(3, 4'hF, rv, d, e, tv, tid, tb, tva, ba, c0);
      chk("t4_rsp_valid", 64'(rv), 64'(4'b1000));
      chk("t4_data", 64'(d), 64'(0));
      chk("t4_err", 64'(e), 64'(1));
      chk("t4_no_trap", 64'(tv | tva), 64'(0));

      // T5: backpressure on requester 0 while 1 waits
      @(posedge clk); #1;
      bus.i_rsp_ready    = 4'b1110;
      bus.i_req_op[0]    = RDTIMEH;
      bus.i_req_valid[0] = 1'b1;
      wait_ready(0, c0);
      @(posedge clk); #1;
      bus.i_req_op[1] = RDCYCLEH;
      bus.i_req_valid = 4'b0010;
      @(negedge clk);
      chk("t5_exec_ready", 64'(bus.o_req_ready), 64'(0));
      repeat (5) begin
         @(negedge clk);
         chk("t5_hold_valid", 64'(bus.o_rsp_valid), 64'(4'b0001));
         chk("t5_hold_data", 64'(bus.o_rsp_data), 64'({4'h3, 28'(c0 + 1)}));
         chk("t5_hold_busy", 64'(busy), 64'(1));
         chk("t5_hold_ready", 64'(bus.o_req_ready), 64'(0));
      end
      @(posedge clk); #1;
      bus.i_rsp_ready = '1;
      @(negedge clk);
      chk("t5_hs_valid", 64'(bus.o_rsp_valid), 64'(4'b0001));
      chk("t5_hs_ready", 64'(bus.o_req_ready), 64'(0));
      @(negedge clk);
      chk("t5_next_ready", 64'(bus.o_req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      bus.i_req_valid = '0;
      repeat (3) @(posedge clk);

      // T6: reset during EXEC aborts the op
      #1;
      bus.i_req_op[2]    = RDCYCLE;
      bus.i_req_valid[2] = 1'b1;
      wait_ready(2, c0);
      @(posedge clk); #1;
      rst_n           = 1'b0;
      bus.i_req_valid = '1;
      #1;
      chk("t6_ready", 64'(bus.o_req_ready), 64'(0));
      chk("t6_rspv", 64'(bus.o_rsp_valid), 64'(0));
      chk("t6_data", 64'(bus.o_rsp_data), 64'(0));
      chk("t6_err", 64'(bus.o_rsp_err), 64'(0));
      chk("t6_exe", 64'(exe_op), 64'(0));
      chk("t6_trap", 64'(trap_valid), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      bus.i_req_valid = '0;
      rst_n           = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("t6_no_rsp", 64'(bus.o_rsp_valid), 64'(0));
         chk("t6_no_trap", 64'(trap_valid), 64'(0));
      end
      @(posedge clk); #1;
      bus.i_req_valid = '1;
      @(negedge clk);
      chk("t6_first_grant", 64'(bus.o_req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      bus.i_req_valid = '0;
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
